// File: rtl/uart_cmd_sequencer_if.sv
// Received-byte input and configuration output bundle of uart_cmd_sequencer.
interface uart_cmd_sequencer_if;
  logic        Rx_Flag;
  logic [7:0]  Rx_Data;
  logic [7:0]  Divider;
  logic        Capture_En;
  logic [15:0] Decimation;
  logic [3:0]  Channel_Sel;
  logic        Cmd_Valid;
  logic        Cmd_Error;
  logic        Busy;

  modport master (
    output Rx_Flag, Rx_Data,
    input  Divider, Capture_En, Decimation, Channel_Sel, Cmd_Valid, Cmd_Error, Busy
  );

  modport slave (
    input  Rx_Flag, Rx_Data,
    output Divider, Capture_En, Decimation, Channel_Sel, Cmd_Valid, Cmd_Error, Busy
  );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// Assembles UART bytes into command frames that program the receiver divider and ADC capture setup.
// Optional XOR checksum byte is compiled in with `define CMD_CHECKSUM_EN.
module uart_cmd_sequencer #(
  parameter logic [7:0]  DEFAULT_DIVIDER = 8'd104,
  parameter logic [15:0] TIMEOUT_CYCLES  = 16'd50000
) (
  input logic                 Sample_Clk,
  input logic                 Reset_N,
  uart_cmd_sequencer_if.slave bus
);
  localparam int unsigned     GapW     = 16;
  localparam logic [7:0]      SyncByte = 8'hA5;
  localparam logic [GapW-1:0] GapLimit = TIMEOUT_CYCLES - 16'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DHI,
    S_DLO,
`ifdef CMD_CHECKSUM_EN
    S_CHK,
`endif
    S_EXEC
  } state_t;

  state_t          state_q, state_n;
  logic            flag_d;
  logic [7:0]      cmd_q, cmd_n;
  logic [7:0]      dhi_q, dhi_n;
  logic [7:0]      dlo_q, dlo_n;
  logic [GapW-1:0] gap_q, gap_n;
  logic [7:0]      divider_q, divider_n;
  logic            capture_q, capture_n;
  logic [15:0]     decimation_q, decimation_n;
  logic [3:0]      channel_q, channel_n;
  logic            valid_q, valid_n;
  logic            error_q, error_n;
  logic            busy_q;
  logic            strobe_c;
  logic            exec_c;
  logic            ok_c;
  logic [7:0]      dlo_c;

  assign strobe_c = bus.Rx_Flag & ~flag_d;

  // Next state, gap counter and command decode. The decode is evaluated in the
  // cycle the last byte arrives so the registered results are visible during EXEC.
  always_comb begin
    state_n      = state_q;
    cmd_n        = cmd_q;
    dhi_n        = dhi_q;
    dlo_n        = dlo_q;
    gap_n        = gap_q;
    divider_n    = divider_q;
    capture_n    = capture_q;
    decimation_n = decimation_q;
    channel_n    = channel_q;
    valid_n      = 1'b0;
    error_n      = 1'b0;
    exec_c       = 1'b0;
    ok_c         = 1'b0;
    dlo_c        = (state_q == S_DLO) ? bus.Rx_Data : dlo_q;

    case (state_q)
      S_IDLE: begin
        gap_n = '0;
        if (strobe_c && (bus.Rx_Data == SyncByte)) state_n = S_CMD;
      end
      S_CMD: if (strobe_c) begin
        cmd_n   = bus.Rx_Data;
        state_n = S_DHI;
      end
      S_DHI: if (strobe_c) begin
        dhi_n   = bus.Rx_Data;
        state_n = S_DLO;
      end
      S_DLO: if (strobe_c) begin
        dlo_n = bus.Rx_Data;
`ifdef CMD_CHECKSUM_EN
        state_n = S_CHK;
`else
        exec_c  = 1'b1;
        state_n = S_EXEC;
`endif
      end
`ifdef CMD_CHECKSUM_EN
      S_CHK: if (strobe_c) begin
        if (bus.Rx_Data == (cmd_q ^ dhi_q ^ dlo_q)) begin
          exec_c  = 1'b1;
          state_n = S_EXEC;
        end else begin
          error_n = 1'b1;
          state_n = S_IDLE;
        end
      end
`endif
      S_EXEC: begin
        gap_n   = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Inter-byte gap tracking while a frame is partially received; a byte beats a timeout.
    if ((state_q != S_IDLE) && (state_q != S_EXEC)) begin
      if (strobe_c) begin
        gap_n = '0;
      end else if (gap_q == GapLimit) begin
        gap_n   = '0;
        error_n = 1'b1;
        state_n = S_IDLE;
      end else if (gap_q != '1) begin
        gap_n = gap_q + 16'd1;
      end
    end

    if (exec_c) begin
      case (cmd_q)
        8'h01: if (dlo_c != 8'h00) begin
          divider_n = dlo_c;
          ok_c      = 1'b1;
        end
        8'h02: begin
          decimation_n = {dhi_q, dlo_c};
          ok_c         = 1'b1;
        end
        8'h03: if (dlo_c[7:4] == 4'h0) begin
          channel_n = dlo_c[3:0];
          ok_c      = 1'b1;
        end
        8'h10: begin
          capture_n = 1'b1;
          ok_c      = 1'b1;
        end
        8'h11: begin
          capture_n = 1'b0;
          ok_c      = 1'b1;
        end
        default: ok_c = 1'b0;
      endcase
      valid_n = ok_c;
      error_n = ~ok_c;
    end
  end

  // Flag history resets high so a flag already asserted at reset release is not a byte.
  always_ff @(posedge Sample_Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q      <= S_IDLE;
      flag_d       <= 1'b1;
      cmd_q        <= '0;
      dhi_q        <= '0;
      dlo_q        <= '0;
      gap_q        <= '0;
      divider_q    <= DEFAULT_DIVIDER;
      capture_q    <= 1'b0;
      decimation_q <= 16'd1;
      channel_q    <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_n;
      flag_d       <= bus.Rx_Flag;
      cmd_q        <= cmd_n;
      dhi_q        <= dhi_n;
      dlo_q        <= dlo_n;
      gap_q        <= gap_n;
      divider_q    <= divider_n;
      capture_q    <= capture_n;
      decimation_q <= decimation_n;
      channel_q    <= channel_n;
      valid_q      <= valid_n;
      error_q      <= error_n;
      busy_q       <= (state_n != S_IDLE);
    end
  end

  assign bus.Divider     = divider_q;
  assign bus.Capture_En  = capture_q;
  assign bus.Decimation  = decimation_q;
  assign bus.Channel_Sel = channel_q;
  assign bus.Cmd_Valid   = valid_q;
  assign bus.Cmd_Error   = error_q;
  assign bus.Busy        = busy_q;
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Bench for uart_cmd_sequencer: directed frame table, corner sequences and random traffic vs a frame-level model.
module tb_uart_cmd_sequencer;
  localparam logic [15:0] TO      = 16'd40;
  localparam logic [7:0]  DEF_DIV = 8'd104;
`ifdef CMD_CHECKSUM_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_sequencer_if bus ();

  uart_cmd_sequencer #(
    .DEFAULT_DIVIDER(DEF_DIV),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .Sample_Clk(clk),
    .Reset_N   (rst_n),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid_seen = 0;
  int n_err_seen = 0;

  // Frame-level reference model
  logic       m_flag_d;
  logic [7:0] m_frame[$];
  int         m_gap;
  bit         m_exec;
  logic [7:0] m_div;
  logic       m_cap;
  logic [15:0] m_dec;
  logic [3:0] m_ch;
  logic       m_valid, m_err;

  function automatic void model_reset();
    m_flag_d = 1'b1;
    m_frame.delete();
    m_gap = 0; m_exec = 0;
    m_div = DEF_DIV; m_cap = 1'b0; m_dec = 16'd1; m_ch = 4'd0;
    m_valid = 1'b0; m_err = 1'b0;
  endfunction

  function automatic void model_frame_done();
    logic [7:0] c, h, l;
    c = m_frame[1]; h = m_frame[2]; l = m_frame[3];
`ifdef CMD_CHECKSUM_EN
    if (m_frame[4] != (c ^ h ^ l)) begin
      m_err = 1'b1;
      return;
    end
`endif
    m_exec = 1;
    case (c)
      8'h01: if (l != 0) begin m_div = l; m_valid = 1'b1; end else m_err = 1'b1;
      8'h02: begin m_dec = {h, l}; m_valid = 1'b1; end
      8'h03: if (l < 8'd16) begin m_ch = l[3:0]; m_valid = 1'b1; end else m_err = 1'b1;
      8'h10: begin m_cap = 1'b1; m_valid = 1'b1; end
      8'h11: begin m_cap = 1'b0; m_valid = 1'b1; end
      default: m_err = 1'b1;
    endcase
  endfunction

  function automatic void model_step(input logic flag, input logic [7:0] data);
    bit strobe;
    strobe = flag && !m_flag_d;
    m_flag_d = flag;
    m_valid = 1'b0; m_err = 1'b0;
    if (m_exec) begin
      m_exec = 0;
      return;
    end
    if (strobe) begin
      m_gap = 0;
      if (m_frame.size() == 0) begin
        if (data == 8'hA5) m_frame.push_back(data);
      end else begin
        m_frame.push_back(data);
        if (m_frame.size() == FLEN) begin
          model_frame_done();
          m_frame.delete();
        end
      end
    end else if (m_frame.size() != 0) begin
      if (m_gap == int'(TO) - 1) begin
        m_err = 1'b1;
        m_frame.delete();
        m_gap = 0;
      end else begin
        m_gap++;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs compared at the falling edge.
  task automatic cycle();
    logic busy_exp;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(bus.Rx_Flag, bus.Rx_Data);
    @(negedge clk);
    busy_exp = (m_frame.size() != 0) || m_exec;
    check("cycle_outputs",
          {bus.Divider, bus.Capture_En, bus.Decimation, bus.Channel_Sel,
           bus.Cmd_Valid, bus.Cmd_Error, bus.Busy},
          {m_div, m_cap, m_dec, m_ch, m_valid, m_err, busy_exp});
    if (bus.Cmd_Valid) n_valid_seen++;
    if (bus.Cmd_Error) n_err_seen++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int low, input int high);
    bus.Rx_Flag = 1'b0;
    repeat (low) cycle();
    bus.Rx_Data = b;
    bus.Rx_Flag = 1'b1;
    repeat (high) cycle();
  endtask

  // Sends a whole frame; the last byte is left with only its strobe cycle elapsed.
  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l);
    send_byte(8'hA5, 1, 2);
    send_byte(c, 1, 2);
    send_byte(h, 1, 2);
`ifdef CMD_CHECKSUM_EN
    send_byte(l, 1, 2);
    send_byte(c ^ h ^ l, 1, 1);
`else
    send_byte(l, 1, 1);
`endif
  endtask

  typedef struct {
    logic [7:0]  cmd, dhi, dlo;
    bit          ok;
    logic [7:0]  div;
    logic        cap;
    logic [15:0] dec;
    logic [3:0]  ch;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int e0, v0;
    logic [7:0] q[$];
    logic [7:0] c, h, l;

    tbl[0] = '{8'h01, 8'h00, 8'h34, 1'b1, 8'h34, 1'b0, 16'h0001, 4'h0};
    tbl[1] = '{8'h02, 8'h12, 8'h34, 1'b1, 8'h34, 1'b0, 16'h1234, 4'h0};
    tbl[2] = '{8'h10, 8'h00, 8'h00, 1'b1, 8'h34, 1'b1, 16'h1234, 4'h0};
    tbl[3] = '{8'h11, 8'h00, 8'h00, 1'b1, 8'h34, 1'b0, 16'h1234, 4'h0};
    tbl[4] = '{8'h55, 8'h00, 8'h00, 1'b0, 8'h34, 1'b0, 16'h1234, 4'h0};
    tbl[5] = '{8'h01, 8'h00, 8'h00, 1'b0, 8'h34, 1'b0, 16'h1234, 4'h0};
    tbl[6] = '{8'h03, 8'h00, 8'h07, 1'b1, 8'h34, 1'b0, 16'h1234, 4'h7};
    tbl[7] = '{8'h03, 8'h00, 8'h17, 1'b0, 8'h34, 1'b0, 16'h1234, 4'h7};
    tbl[8] = '{8'h02, 8'h00, 8'h00, 1'b1, 8'h34, 1'b0, 16'h0000, 4'h7};
    tbl[9] = '{8'h01, 8'h00, 8'hFF, 1'b1, 8'hFF, 1'b0, 16'h0000, 4'h7};

    // Reset with the flag held high from before release
    model_reset();
    bus.Rx_Flag = 1'b1;
    bus.Rx_Data = 8'hA5;
    repeat (3) @(negedge clk);
    check("reset_values", {bus.Divider, bus.Capture_En, bus.Decimation, bus.Channel_Sel,
                           bus.Cmd_Valid, bus.Cmd_Error, bus.Busy},
          {8'd104, 1'b0, 16'd1, 4'd0, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;
    repeat (5) cycle();
    check("flag_held_no_byte", 32'(bus.Busy), 32'd0);

    // Directed frame table
    for (int i = 0; i < 10; i++) begin
      send_frame(tbl[i].cmd, tbl[i].dhi, tbl[i].dlo);
      check($sformatf("tbl%0d_pulse", i), {30'd0, bus.Cmd_Valid, bus.Cmd_Error},
            tbl[i].ok ? 32'd2 : 32'd1);
      check($sformatf("tbl%0d_cfg", i), {bus.Divider, bus.Capture_En, bus.Decimation, bus.Channel_Sel},
            {tbl[i].div, tbl[i].cap, tbl[i].dec, tbl[i].ch});
      cycle();
      check($sformatf("tbl%0d_pulse_width", i), {30'd0, bus.Cmd_Valid, bus.Cmd_Error}, 32'd0);
    end

    // Stall after A5,02: exactly one error pulse, then idle
    e0 = n_err_seen;
    send_byte(8'hA5, 1, 1);
    send_byte(8'h02, 1, 1);
    bus.Rx_Flag = 1'b0;
    repeat (int'(TO) + 4) cycle();
    check("timeout_err_pulses", 32'(n_err_seen - e0), 32'd1);
    check("timeout_busy", 32'(bus.Busy), 32'd0);
    send_frame(8'h02, 8'hAB, 8'hCD);
    check("after_timeout_exec", {15'd0, bus.Cmd_Valid, bus.Decimation}, {15'd0, 1'b1, 16'hABCD});
    cycle();

    // Byte arriving in the very cycle the gap limit is reached keeps the frame alive
    e0 = n_err_seen;
    send_byte(8'hA5, 1, 1);
    send_byte(8'h02, 1, 1);
    send_byte(8'h00, int'(TO) - 1, 1);
    check("byte_beats_timeout", {30'd0, bus.Busy, bus.Cmd_Error}, 32'd2);
`ifdef CMD_CHECKSUM_EN
    send_byte(8'h42, 1, 2);
    send_byte(8'h02 ^ 8'h42, 1, 1);
`else
    send_byte(8'h42, 1, 1);
`endif
    check("byte_beats_timeout_exec", {15'd0, bus.Cmd_Valid, bus.Decimation}, {15'd0, 1'b1, 16'h0042});
    check("byte_beats_timeout_noerr", 32'(n_err_seen - e0), 32'd0);
    cycle();

    // Leading junk is dropped without error
    e0 = n_err_seen;
    send_byte(8'h00, 1, 2);
    send_byte(8'hFF, 1, 2);
    check("junk_not_busy", 32'(bus.Busy), 32'd0);
    send_frame(8'h10, 8'h00, 8'h00);
    check("junk_then_capture", {30'd0, bus.Capture_En, bus.Cmd_Valid}, 32'd3);
    check("junk_no_error", 32'(n_err_seen - e0), 32'd0);
    cycle();

`ifdef CMD_CHECKSUM_EN
    // Bad checksum: error the next cycle, straight back to idle, divider untouched
    send_byte(8'hA5, 1, 2);
    send_byte(8'h01, 1, 2);
    send_byte(8'h00, 1, 2);
    send_byte(8'h34, 1, 2);
    send_byte(8'h00, 1, 1);
    check("bad_chk", {bus.Divider, 21'd0, bus.Cmd_Error, bus.Cmd_Valid, bus.Busy},
          {8'hFF, 21'd0, 1'b1, 1'b0, 1'b0});
    cycle();
`endif

    // Reset in the middle of a frame
    e0 = n_err_seen;
    send_byte(8'hA5, 1, 2);
    send_byte(8'h01, 1, 2);
    bus.Rx_Flag = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midframe_reset", {bus.Divider, bus.Capture_En, bus.Decimation, bus.Channel_Sel,
                             bus.Cmd_Valid, bus.Cmd_Error, bus.Busy},
          {8'd104, 1'b0, 16'd1, 4'd0, 1'b0, 1'b0, 1'b0});
    model_reset();
    repeat (2) cycle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle();
    check("midframe_reset_noerr", 32'(n_err_seen - e0), 32'd0);

    // Random traffic against the model
    v0 = n_valid_seen;
    for (int f = 0; f < 250; f++) begin
      q.delete();
      if ($urandom_range(0, 3) == 0) begin
        l = 8'($urandom);
        q.push_back((l == 8'hA5) ? 8'h00 : l);
      end
      case ($urandom_range(0, 5))
        0: c = 8'h01;
        1: c = 8'h02;
        2: c = 8'h03;
        3: c = 8'h10;
        4: c = 8'h11;
        default: c = 8'($urandom);
      endcase
      h = 8'($urandom);
      l = 8'($urandom);
      if (c == 8'h03 && $urandom_range(0, 1) == 1) l[7:4] = 4'h0;
      if (c == 8'h01 && $urandom_range(0, 4) == 0) l = 8'h00;
      q.push_back(8'hA5);
      q.push_back(c);
      q.push_back(h);
      q.push_back(l);
`ifdef CMD_CHECKSUM_EN
      q.push_back(($urandom_range(0, 6) == 0) ? 8'($urandom) : (c ^ h ^ l));
`endif
      foreach (q[k]) begin
        if ($urandom_range(0, 24) == 0)
          send_byte(q[k], $urandom_range(int'(TO) - 4, int'(TO) + 2), $urandom_range(1, 3));
        else
          send_byte(q[k], $urandom_range(1, 3), $urandom_range(1, 3));
      end
    end
    bus.Rx_Flag = 1'b0;
    repeat (int'(TO) + 4) cycle();
    check("random_some_valid", 32'(n_valid_seen - v0 > 20), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
